piece_sequencer: RTL and testbench

- Controller between randombag and game logic.
- Requests 7-bag generations from randombag (newbag/ready handshake) and checks each bag is a valid permutation of pieces 0..6.
- Buffers accepted pieces in an ordered queue and hands them out one per request, with a preview window of upcoming pieces.
- Keeps the queue topped up: a new bag is requested whenever the queue has room for one.

---
 rtl/tetris_pkg.sv | 32 +++
 rtl/piece_queue.sv | 95 +++++++++
 rtl/piece_sequencer.sv | 144 ++++++++++++++
 tb/tb_piece_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris piece pipeline.
// Holds the piece/bag geometry, the piece code type, the sequencer state
// encoding and the 7-bag permutation check. The check is also used by the
// randombag bench.
package tetris_pkg;

  localparam int PIECE_W  = 3;
  localparam int BAG_SIZE = 7;
  localparam int BAG_W    = 21;

  typedef logic [PIECE_W-1:0] piece_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    CHECK = 2'd3
  } seq_state_t;

  // A bag is valid when its seven fields cover codes 0..6.
  // Seven fields that reach seven distinct codes in 0..6 must each appear
  // exactly once. A code of 7 sets bit 7, which also fails the compare.
  function automatic logic bag_is_permutation(input logic [BAG_W-1:0] bag);
    logic [7:0] seen;
    seen = 8'h00;
    for (int k = 0; k < BAG_SIZE; k++) begin
      seen[bag[PIECE_W*k +: PIECE_W]] = 1'b1;
    end
    return (seen == 8'h7F);
  endfunction

endpackage

// File: rtl/piece_queue.sv
// Ordered shift-register piece queue with push-7 / pop-1 ports.
// Ports:
//   clk, nreset      - clock and asynchronous active-low reset
//   i_push           - append all 7 pieces of i_push_bag (field 0 first)
//   i_push_bag       - 21-bit bag, piece k = bits [3k+2:3k]
//   i_pop_req        - pop the head. Ignored when the queue is empty.
//   o_valid          - queue is non-empty
//   o_head           - entry 0
//   o_preview        - entries 1..PREVIEW, slot i = bits [3i+2:3i]
//   o_preview_valid  - count >= PREVIEW+1
//   o_count          - pieces currently held
// Unused entries always hold 0, so the head and preview slots read 0 past
// the end of the queue.
module piece_queue
  import tetris_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int PREVIEW = 3
) (
  input  logic                         clk,
  input  logic                         nreset,
  input  logic                         i_push,
  input  logic [BAG_W-1:0]             i_push_bag,
  input  logic                         i_pop_req,
  output logic                         o_valid,
  output logic [PIECE_W-1:0]           o_head,
  output logic [PIECE_W*PREVIEW-1:0]   o_preview,
  output logic                         o_preview_valid,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int CW = $clog2(DEPTH+1);

  piece_t          r_q [DEPTH];
  logic [CW-1:0]   r_count;

  piece_t          w_q_next [DEPTH];
  piece_t          w_shift [DEPTH];
  logic            w_pop;
  logic [CW-1:0]   w_count_next;
  int              w_base;

  assign w_pop = i_pop_req & (r_count != '0);

  // Next queue image: the pop shift happens first, then the bag lands at
  // the first free slot after the shift.
  always_comb begin
    w_base = int'(r_count) - (w_pop ? 1 : 0);
    for (int i = 0; i < DEPTH - 1; i++) begin
      w_shift[i] = w_pop ? r_q[i+1] : r_q[i];
    end
    w_shift[DEPTH-1] = w_pop ? piece_t'(3'd0) : r_q[DEPTH-1];
    for (int i = 0; i < DEPTH; i++) begin : g_slot
      int ofs;
      ofs = i - w_base;
      if (i_push && (ofs >= 0) && (ofs < BAG_SIZE)) begin
        w_q_next[i] = piece_t'(i_push_bag >> (PIECE_W*ofs));
      end else begin
        w_q_next[i] = w_shift[i];
      end
    end
    w_count_next = r_count
                 + (i_push ? CW'(BAG_SIZE) : CW'(0))
                 - (w_pop  ? CW'(1)        : CW'(0));
  end

  // Queue storage and occupancy.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i] <= '0;
      end
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i] <= w_q_next[i];
      end
      r_count <= w_count_next;
    end
  end

  // Preview window is a direct view of entries 1..PREVIEW.
  always_comb begin
    o_preview = '0;
    for (int i = 0; i < PREVIEW; i++) begin
      o_preview[PIECE_W*i +: PIECE_W] = r_q[i+1];
    end
  end

  assign o_head          = r_q[0];
  assign o_valid         = (r_count != '0);
  assign o_preview_valid = (r_count >= CW'(PREVIEW + 1));
  assign o_count         = r_count;

endmodule

// File: rtl/piece_sequencer.sv
// Piece sequencer. It requests 7-bags from randombag, rejects bags that are
// not permutations, and feeds accepted pieces to the game through an
// ordered queue with a preview window.
// Ports:
//   clk, nreset    - clock and asynchronous active-low reset
//   bag_newbag     - one-cycle request pulse to randombag
//   bag_ready      - randombag ready. Its rising edge delivers a bag.
//   bag_pieces     - 21-bit bag, piece k = bits [3k+2:3k]
//   piece_req      - consumer pops the head piece
//   piece_valid    - queue non-empty
//   piece_out      - head piece code
//   preview        - next PREVIEW pieces after the head
//   preview_valid  - at least PREVIEW+1 pieces queued
//   count          - pieces queued
//   bag_err        - sticky: a bad bag was seen
//   timeout_err    - sticky: a request timed out at least once
module piece_sequencer
  import tetris_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int PREVIEW = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic                         clk,
  input  logic                         nreset,
  output logic                         bag_newbag,
  input  logic                         bag_ready,
  input  logic [BAG_W-1:0]             bag_pieces,
  input  logic                         piece_req,
  output logic                         piece_valid,
  output logic [PIECE_W-1:0]           piece_out,
  output logic [PIECE_W*PREVIEW-1:0]   preview,
  output logic                         preview_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         bag_err,
  output logic                         timeout_err
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  seq_state_t        r_state;
  logic              r_newbag;
  logic              r_ready_q;
  logic              r_bag_err;
  logic              r_timeout_err;
  logic [TW-1:0]     r_tmo;
  logic [BAG_W-1:0]  r_bag;

  logic              w_ready_edge;
  logic              w_bag_ok;
  logic              w_push;
  logic              w_pop;
  logic              w_room;
  logic [CW-1:0]     w_count;

  assign w_ready_edge = bag_ready & ~r_ready_q;
  assign w_bag_ok     = bag_is_permutation(r_bag);
  assign w_push       = (r_state == CHECK) & w_bag_ok;
  assign w_pop        = piece_req & piece_valid;
  // Room for another bag, judged on the occupancy after this cycle's pop.
  assign w_room       = ((w_count - {{(CW-1){1'b0}}, w_pop}) <= CW'(DEPTH - BAG_SIZE));

  // Request/validate FSM. It also holds the timeout counter, the captured
  // bag and the sticky error flags.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state       <= IDLE;
      r_newbag      <= 1'b0;
      r_ready_q     <= 1'b0;
      r_bag_err     <= 1'b0;
      r_timeout_err <= 1'b0;
      r_tmo         <= '0;
      r_bag         <= '0;
    end else begin
      r_ready_q <= bag_ready;
      case (r_state)
        IDLE: begin
          if (w_room) begin
            r_state  <= REQ;
            r_newbag <= 1'b1;
          end else begin
            r_newbag <= 1'b0;
          end
        end
        REQ: begin
          r_state  <= WAIT;
          r_newbag <= 1'b0;
          r_tmo    <= '0;
        end
        WAIT: begin
          if (w_ready_edge) begin
            r_bag    <= bag_pieces;
            r_state  <= CHECK;
            r_newbag <= 1'b0;
          end else if (r_tmo == TW'(TIMEOUT - 1)) begin
            r_timeout_err <= 1'b1;
            r_state       <= REQ;
            r_newbag      <= 1'b1;
          end else begin
            r_tmo    <= r_tmo + TW'(1);
            r_newbag <= 1'b0;
          end
        end
        CHECK: begin
          if (w_bag_ok) begin
            r_state  <= IDLE;
            r_newbag <= 1'b0;
          end else begin
            r_bag_err <= 1'b1;
            r_state   <= REQ;
            r_newbag  <= 1'b1;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_newbag <= 1'b0;
        end
      endcase
    end
  end

  piece_queue #(
    .DEPTH   (DEPTH),
    .PREVIEW (PREVIEW)
  ) u_queue (
    .clk             (clk),
    .nreset          (nreset),
    .i_push          (w_push),
    .i_push_bag      (r_bag),
    .i_pop_req       (piece_req),
    .o_valid         (piece_valid),
    .o_head          (piece_out),
    .o_preview       (preview),
    .o_preview_valid (preview_valid),
    .o_count         (w_count)
  );

  assign count       = w_count;
  assign bag_newbag  = r_newbag;
  assign bag_err     = r_bag_err;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_piece_sequencer.sv
// Directed bench for piece_sequencer. Expected values are worked out by
// hand from the bag contents and the FSM timing.
module tb_piece_sequencer;

  logic        clk;
  logic        nreset;
  logic        bag_newbag;
  logic        bag_ready;
  logic [20:0] bag_pieces;
  logic        piece_req;
  logic        piece_valid;
  logic [2:0]  piece_out;
  logic [8:0]  preview;
  logic        preview_valid;
  logic [4:0]  count;
  logic        bag_err;
  logic        timeout_err;

  int tests = 0;
  int fails = 0;

  piece_sequencer #(.DEPTH(16), .PREVIEW(3), .TIMEOUT(1024)) dut (
    .clk           (clk),
    .nreset        (nreset),
    .bag_newbag    (bag_newbag),
    .bag_ready     (bag_ready),
    .bag_pieces    (bag_pieces),
    .piece_req     (piece_req),
    .piece_valid   (piece_valid),
    .piece_out     (piece_out),
    .preview       (preview),
    .preview_valid (preview_valid),
    .count         (count),
    .bag_err       (bag_err),
    .timeout_err   (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check("count_le_depth", {31'd0, (count <= 5'd16)}, 32'd1);
  endtask

  function automatic logic [20:0] mk(input int a0, input int a1, input int a2, input int a3,
                                     input int a4, input int a5, input int a6);
    return {3'(a6), 3'(a5), 3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  // Wait (bounded) for a request pulse, then deliver a bag with a ready edge.
  // Returns one cycle after CHECK, when the queue is updated.
  task automatic do_bag(input logic [20:0] p);
    int n = 0;
    while (!bag_newbag && n < 3000) begin
      step();
      n++;
    end
    check("newbag_seen", {31'd0, bag_newbag}, 32'd1);
    step();
    bag_pieces = p;
    bag_ready  = 1'b1;
    step();
    bag_ready  = 1'b0;
    step();
  endtask

  initial begin
    int n;
    int req_cnt;
    logic [2:0] exp_seq [8];
    exp_seq = '{3'd3, 3'd0, 3'd6, 3'd1, 3'd5, 3'd2, 3'd4, 3'd6};

    nreset     = 1'b0;
    bag_ready  = 1'b0;
    bag_pieces = 21'd0;
    piece_req  = 1'b0;
    #12;
    check("rst_count",   {27'd0, count}, 32'd0);
    check("rst_valid",   {31'd0, piece_valid}, 32'd0);
    check("rst_out",     {29'd0, piece_out}, 32'd0);
    check("rst_preview", {23'd0, preview}, 32'd0);
    check("rst_newbag",  {31'd0, bag_newbag}, 32'd0);
    check("rst_errs",    {30'd0, bag_err, timeout_err}, 32'd0);

    // Reset release: request on first clock, first bag lands, second follows
    @(posedge clk);
    #1;
    nreset = 1'b1;
    step();
    check("newbag_cycle1", {31'd0, bag_newbag}, 32'd1);
    do_bag(mk(3, 0, 6, 1, 5, 2, 4));
    check("bagA_head",    {29'd0, piece_out}, 32'd3);
    check("bagA_preview", {23'd0, preview}, {23'd0, 3'd1, 3'd6, 3'd0});
    check("bagA_count",   {27'd0, count}, 32'd7);
    check("bagA_pvalid",  {31'd0, preview_valid}, 32'd1);
    step();
    check("second_req",   {31'd0, bag_newbag}, 32'd1);
    do_bag(mk(6, 5, 4, 3, 2, 1, 0));
    check("bagB_count",   {27'd0, count}, 32'd14);
    step();
    check("full_no_req",  {31'd0, bag_newbag}, 32'd0);

    // Eight back-to-back pops from count 14
    req_cnt = -1;
    for (int i = 0; i < 8; i++) begin
      check("pop_order", {29'd0, piece_out}, {29'd0, exp_seq[i]});
      piece_req = 1'b1;
      step();
      if (bag_newbag && req_cnt < 0) req_cnt = int'(count);
    end
    piece_req = 1'b0;
    check("req_at_count9", req_cnt, 32'd9);
    check("pop8_count",    {27'd0, count}, 32'd6);
    check("pop8_head",     {29'd0, piece_out}, 32'd5);

    // Invalid bag while in WAIT
    bag_pieces = mk(1, 1, 2, 3, 4, 5, 6);
    bag_ready  = 1'b1;
    step();
    bag_ready  = 1'b0;
    check("bad_no_req_yet", {31'd0, bag_newbag}, 32'd0);
    step();
    check("bag_err_set",    {31'd0, bag_err}, 32'd1);
    check("bad_count",      {27'd0, count}, 32'd6);
    check("bad_rereq",      {31'd0, bag_newbag}, 32'd1);
    do_bag(mk(0, 1, 2, 3, 4, 5, 6));
    check("bagC_count",   {27'd0, count}, 32'd13);
    check("bagC_head",    {29'd0, piece_out}, 32'd5);
    check("bagC_preview", {23'd0, preview}, {23'd0, 3'd2, 3'd3, 3'd4});

    // Drain to 2, then pop in the same cycle as CHECK
    piece_req = 1'b1;
    for (int i = 0; i < 11; i++) step();
    piece_req = 1'b0;
    check("drain_count",   {27'd0, count}, 32'd2);
    check("drain_head",    {29'd0, piece_out}, 32'd5);
    check("drain_preview", {23'd0, preview}, {23'd0, 3'd0, 3'd0, 3'd6});
    check("drain_pvalid",  {31'd0, preview_valid}, 32'd0);
    bag_pieces = mk(2, 4, 6, 1, 3, 5, 0);
    bag_ready  = 1'b1;
    step();
    bag_ready  = 1'b0;
    piece_req  = 1'b1;
    step();
    piece_req  = 1'b0;
    check("popchk_count", {27'd0, count}, 32'd8);
    check("popchk_head",  {29'd0, piece_out}, 32'd6);
    check("popchk_prev",  {23'd0, preview}, {23'd0, 3'd6, 3'd4, 3'd2});

    // Timeout: no ready, check retry period
    n = 0;
    while (!bag_newbag && n < 10) begin
      step();
      n++;
    end
    check("tmo_first_req", {31'd0, bag_newbag}, 32'd1);
    check("tmo_err_clear", {31'd0, timeout_err}, 32'd0);
    for (int r = 0; r < 2; r++) begin
      n = 0;
      step();
      n++;
      while (!bag_newbag && n < 1200) begin
        step();
        n++;
      end
      check("tmo_period", n, 32'd1025);
      check("tmo_err_set", {31'd0, timeout_err}, 32'd1);
    end
    check("tmo_count", {27'd0, count}, 32'd8);

    // Reset during WAIT, then a stale ready edge after release
    step();
    nreset = 1'b0;
    step();
    step();
    check("mrst_count",  {27'd0, count}, 32'd0);
    check("mrst_out",    {29'd0, piece_out}, 32'd0);
    check("mrst_prev",   {23'd0, preview}, 32'd0);
    check("mrst_flags",  {27'd0, piece_valid, preview_valid, bag_newbag, bag_err, timeout_err}, 32'd0);
    nreset     = 1'b1;
    bag_ready  = 1'b1;
    bag_pieces = mk(3, 0, 6, 1, 5, 2, 4);
    piece_req  = 1'b1;
    step();
    check("mrst_req_next", {31'd0, bag_newbag}, 32'd1);
    for (int i = 0; i < 3; i++) step();
    check("stale_ignored", {27'd0, count}, 32'd0);
    check("stale_valid",   {31'd0, piece_valid}, 32'd0);
    check("stale_no_err",  {31'd0, bag_err}, 32'd0);
    bag_ready = 1'b0;
    piece_req = 1'b0;
    step();
    bag_ready = 1'b1;
    step();
    bag_ready = 1'b0;
    step();
    check("recover_count", {27'd0, count}, 32'd7);
    check("recover_head",  {29'd0, piece_out}, 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
